softmax_max_scan: RTL and testbench
===================================

SOFTMAX_MAX_SCAN -- requirements
Module: softmax_max_scan

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed element width.
REQ-002 SHALL have parameter VEC_LEN, default 8, elements per softmax vector (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port sort_en  input  1  stage-1 window from the softmax controller; high for the whole scan.
REQ-006 SHALL have port in_valid  input  1  element beat present.
REQ-007 SHALL have port in_data  input  DATA_W  element Xi, two's complement.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port max_valid  output  1  Xmax result valid.
REQ-010 SHALL have port max_data  output  DATA_W  Xmax, signed.
REQ-011 SHALL have port max_idx  output  $clog2(VEC_LEN)  index of Xmax within the vector.
REQ-012 SHALL have port scan_abort  output  1  one-cycle pulse when a scan is cut short.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE (one-hot encoded).
REQ-014 IDLE->SCAN SHALL occur on the first cycle sort_en=1; IDLE otherwise holds.
REQ-015 in_ready SHALL be 1 only in SCAN; a beat is accepted when in_valid & in_ready.
REQ-016 SHALL load the first accepted beat of a vector unconditionally into max_data, with index 0.
REQ-017 Each later beat SHALL replace max_data only if strictly greater (signed compare); ties keep the earlier element and index.
REQ-018 SHALL count accepted beats in a counter of width $clog2(VEC_LEN+1); index = count value at acceptance.
REQ-019 After the VEC_LEN-th accept, SHALL enter DONE on the next edge; max_valid=1 in that same cycle (latency 1 cycle from the last accept).
REQ-020 In DONE, SHALL hold max_valid=1, in_ready=0, and max_data/max_idx stable; beats offered are ignored.
REQ-021 DONE->IDLE SHALL occur when sort_en=0; max_valid drops the cycle after.
REQ-022 max_data and max_idx SHALL keep their values in IDLE until the first accept of the next scan (stage 2 reads them after sort_en falls).
REQ-023 sort_en=0 in SCAN SHALL abort: return to IDLE, pulse scan_abort for 1 cycle, clear count, keep max_valid=0.
REQ-024 in_valid gaps in SCAN SHALL stall the count with no effect on the result.
REQ-025 A beat accepted in the cycle sort_en falls SHALL be discarded (abort takes priority).

Reset
REQ-026 On rst: state=IDLE, count=0, in_ready=0, max_valid=0, scan_abort=0, max_data=0, max_idx=0.
REQ-027 rst SHALL override every event in the same cycle, including a mid-scan accept; no scan_abort pulse is produced by reset.

Configuration
REQ-028 Macro SOFTMAX_MAX_IDX_EN: when defined, max_idx tracks argmax per REQ-016/017.
REQ-029 When not defined, no index register SHALL be built and max_idx SHALL be tied to 0; max_data behaviour is unchanged.

Structure
REQ-030 softmax_pkg SHALL hold DATA_W/VEC_LEN defaults and the FSM state encodings, shared with softmax_controller.
REQ-031 The signed compare/select SHALL be one sub-module, softmax_max_cmp (combinational: a, b -> gt).
REQ-032 The total RTL SHALL be 120-400 lines.

Verification
REQ-033 VEC_LEN=8, inputs 3,-5,12,7,12,0,-1,4 -> max_data=12, max_idx=2, max_valid 1 cycle after the 8th accept.
REQ-034 All elements negative: -9,-2,-7,-32768,-3,-2,-8,-100 -> max_data=-2, max_idx=1 (tie keeps first).
REQ-035 Random in_valid gaps with the same vector as REQ-033 -> identical result; in_ready=1 throughout SCAN.
REQ-036 sort_en dropped after 4 accepts -> scan_abort pulses once, max_valid stays 0, FSM in IDLE; the next full scan yields a correct max.
REQ-037 rst asserted in DONE -> all outputs 0 next cycle; without SOFTMAX_MAX_IDX_EN, max_idx=0 in every case.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared softmax defaults and scan FSM state encodings.
package softmax_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned VEC_LEN_DEF = 8;

  // One-hot scan states, shared with the softmax controller.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SCAN = 3'b010,
    DONE = 3'b100
  } scan_state_e;

endpackage

// File: rtl/softmax_max_cmp.sv
// Signed greater-than compare used by the running-max select.
module softmax_max_cmp #(
  parameter int unsigned DATA_W = softmax_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt
);

  // gt is set only when a is strictly greater than b, two's complement.
  always_comb begin
    gt = ($signed(a) > $signed(b));
  end

endmodule

// File: rtl/softmax_max_scan.sv
// Stage-1 softmax scan: finds Xmax (and optionally its index) over one vector.
// Optional feature: define SOFTMAX_MAX_IDX_EN to build the argmax index register;
// otherwise max_idx is tied to zero.
module softmax_max_scan
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned VEC_LEN = VEC_LEN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sort_en,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       max_valid,
  output logic [DATA_W-1:0]          max_data,
  output logic [$clog2(VEC_LEN)-1:0] max_idx,
  output logic                       scan_abort
);

  localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
  localparam int unsigned IDX_W = $clog2(VEC_LEN);

  scan_state_e      state;
  scan_state_e      state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             abort_c;
  logic             accept;
  logic             take;
  logic             gt;

  // Abort has priority: a beat offered while sort_en is low is never accepted.
  assign accept = in_valid & in_ready & sort_en;

  softmax_max_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .a  (in_data),
    .b  (max_data),
    .gt (gt)
  );

  // First beat of a vector loads unconditionally; later beats only if strictly greater.
  assign take = accept & ((count == '0) | gt);

  // Next-state, beat counter and abort decode.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    abort_c   = 1'b0;
    unique case (state)
      IDLE: begin
        count_nxt = '0;
        if (sort_en) begin
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!sort_en) begin
          state_nxt = IDLE;
          count_nxt = '0;
          abort_c   = 1'b1;
        end else if (accept) begin
          count_nxt = count + CNT_W'(1);
          if (count == CNT_W'(VEC_LEN - 1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!sort_en) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // State, counter and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      in_ready   <= 1'b0;
      max_valid  <= 1'b0;
      scan_abort <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      in_ready   <= (state_nxt == SCAN);
      max_valid  <= (state_nxt == DONE);
      scan_abort <= abort_c;
    end
  end

  // Running maximum; holds through DONE and IDLE until the next scan's first accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_data <= '0;
    end else if (take) begin
      max_data <= in_data;
    end
  end

`ifdef SOFTMAX_MAX_IDX_EN
  logic [IDX_W-1:0] idx_q;

  // Argmax index follows the same load rule as max_data; ties keep the earlier index.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (take) begin
      idx_q <= IDX_W'(count);
    end
  end

  assign max_idx = idx_q;
`else
  assign max_idx = '0;
`endif

endmodule

// File: tb/tb_softmax_max_scan.sv
// Self-checking bench for softmax_max_scan (VEC_LEN=8, DATA_W=16).
module tb_softmax_max_scan;

  localparam int P_IDLE = 0;
  localparam int P_SCAN = 1;
  localparam int P_DONE = 2;
`ifdef SOFTMAX_MAX_IDX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sort_en;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        max_valid;
  logic [15:0] max_data;
  logic [2:0]  max_idx;
  logic        scan_abort;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_max_scan #(
    .DATA_W  (16),
    .VEC_LEN (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sort_en    (sort_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .max_valid  (max_valid),
    .max_data   (max_data),
    .max_idx    (max_idx),
    .scan_abort (scan_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: collects the accepted beats of the current vector and
  // derives the max as the first occurrence of the largest value.
  int                 exp_phase = P_IDLE;
  logic signed [15:0] exp_data  = '0;
  int                 exp_idx   = 0;
  bit                 exp_abort = 1'b0;
  logic signed [15:0] beats[$];

  always @(posedge clk) begin
    if (rst) begin
      exp_phase = P_IDLE;
      exp_data  = '0;
      exp_idx   = 0;
      exp_abort = 1'b0;
      beats.delete();
    end else begin
      exp_abort = 1'b0;
      case (exp_phase)
        P_IDLE: if (sort_en) begin
          exp_phase = P_SCAN;
          beats.delete();
        end
        P_SCAN: begin
          if (!sort_en) begin
            exp_phase = P_IDLE;
            exp_abort = 1'b1;
            beats.delete();
          end else if (in_valid) begin
            beats.push_back(in_data);
            exp_data = beats[0];
            exp_idx  = 0;
            for (int i = 1; i < beats.size(); i++) begin
              if (beats[i] > exp_data) begin
                exp_data = beats[i];
                exp_idx  = i;
              end
            end
            if (beats.size() == 8) exp_phase = P_DONE;
          end
        end
        default: if (!sort_en) exp_phase = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("in_ready",   int'(in_ready),   int'(exp_phase == P_SCAN));
    chk("max_valid",  int'(max_valid),  int'(exp_phase == P_DONE));
    chk("scan_abort", int'(scan_abort), int'(exp_abort));
    chk("max_data",   int'($signed(max_data)), int'(exp_data));
    chk("max_idx",    int'(max_idx),    IDX_EN ? exp_idx : 0);
  end

  // Drive one cycle of inputs just after the falling edge.
  task automatic step(input bit r, input bit se, input bit v, input logic [15:0] d);
    @(negedge clk);
    #1;
    rst      = r;
    sort_en  = se;
    in_valid = v;
    in_data  = d;
  endtask

  // Full scan; on return the DONE cycle is observable.
  task automatic run_scan(input logic [15:0] vec[8], input bit gaps);
    step(0, 1, 1, 16'd99);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step(0, 1, 0, 16'h7abc);
      end
      step(0, 1, 1, vec[i]);
    end
    step(0, 1, 0, 16'd0);
  endtask

  logic [15:0] vec_a[8];
  logic [15:0] vec_b[8];

  initial begin
    vec_a = '{16'd3, -16'sd5, 16'd12, 16'd7, 16'd12, 16'd0, -16'sd1, 16'd4};
    vec_b = '{-16'sd9, -16'sd2, -16'sd7, -16'sd32768, -16'sd3, -16'sd2, -16'sd8, -16'sd100};
    rst = 1'b1; sort_en = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) step(1, 0, 0, 16'd0);
    step(0, 0, 0, 16'd0);
    chk("reset max_valid", int'(max_valid), 0);
    chk("reset in_ready",  int'(in_ready),  0);

    // Basic vector, then DONE hold with ignored beats.
    run_scan(vec_a, 1'b0);
    chk("vec_a valid", int'(max_valid), 1);
    chk("vec_a data",  int'($signed(max_data)), 12);
    chk("vec_a idx",   int'(max_idx), IDX_EN ? 2 : 0);
    step(0, 1, 1, 16'd30000);
    step(0, 1, 1, 16'd30000);
    step(0, 0, 0, 16'd0);
    step(0, 0, 0, 16'd0);
    chk("idle hold valid", int'(max_valid), 0);
    chk("idle hold data",  int'($signed(max_data)), 12);

    // All negative with a tie on the max.
    run_scan(vec_b, 1'b0);
    chk("vec_b data", int'($signed(max_data)), -2);
    chk("vec_b idx",  int'(max_idx), IDX_EN ? 1 : 0);
    step(0, 0, 0, 16'd0);

    // Same vector as the first, with input gaps.
    run_scan(vec_a, 1'b1);
    chk("gaps data", int'($signed(max_data)), 12);
    chk("gaps idx",  int'(max_idx), IDX_EN ? 2 : 0);
    step(0, 0, 0, 16'd0);

    // Abort after 4 accepts; beat offered as sort_en falls is discarded.
    step(0, 1, 0, 16'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, vec_b[i]);
    step(0, 0, 1, 16'd77);
    step(0, 0, 0, 16'd0);
    chk("abort pulse", int'(scan_abort), 1);
    chk("abort valid", int'(max_valid), 0);
    step(0, 0, 0, 16'd0);
    chk("abort single", int'(scan_abort), 0);
    chk("abort partial data", int'($signed(max_data)), -2);

    // Rescan after abort, then reset in DONE.
    run_scan(vec_a, 1'b0);
    chk("rescan data", int'($signed(max_data)), 12);
    step(1, 1, 1, 16'd5);
    step(0, 0, 0, 16'd0);
    chk("rst done valid", int'(max_valid), 0);
    chk("rst done data",  int'($signed(max_data)), 0);
    chk("rst done idx",   int'(max_idx), 0);

    // Reset overriding a mid-scan accept; no abort pulse.
    step(0, 1, 0, 16'd0);
    step(0, 1, 1, 16'd100);
    step(1, 1, 1, 16'd200);
    step(0, 0, 0, 16'd0);
    chk("rst scan abort", int'(scan_abort), 0);
    chk("rst scan data",  int'($signed(max_data)), 0);
    step(0, 0, 0, 16'd0);
    chk("rst scan abort late", int'(scan_abort), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
